// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants used by the fetch front end and its bench.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INCR   = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_id_stage_if.sv
// Hazard/redirect controls, instruction memory link and IF/ID outputs of the fetch stage.
interface if_id_stage_if #(
    parameter int CNT_W = 16
);
    import riscv_pkg::*;

    logic            PCWrite_i;
    logic            Stall_i;
    logic            Flush_i;
    logic [XLEN-1:0] BranchTarget_i;
    logic [XLEN-1:0] instr_i;
    logic [XLEN-1:0] instr_addr_o;
    logic [XLEN-1:0] IF_ID_PC_o;
    logic [XLEN-1:0] IF_ID_Instr_o;
    logic            IF_ID_Valid_o;
    logic [CNT_W-1:0] StallCount_o;
    logic [CNT_W-1:0] FlushCount_o;

    modport master (
        output PCWrite_i, Stall_i, Flush_i, BranchTarget_i, instr_i,
        input  instr_addr_o, IF_ID_PC_o, IF_ID_Instr_o, IF_ID_Valid_o,
        input  StallCount_o, FlushCount_o
    );

    modport slave (
        input  PCWrite_i, Stall_i, Flush_i, BranchTarget_i, instr_i,
        output instr_addr_o, IF_ID_PC_o, IF_ID_Instr_o, IF_ID_Valid_o,
        output StallCount_o, FlushCount_o
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] val);
        if (&val)
            return val;
        return val + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            count_o <= '0;
        else if (inc_i)
            count_o <= sat_inc(count_o);
    end

endmodule

// File: rtl/if_id_stage.sv
// Fetch front end: PC register with branch redirect, IF/ID register, stall/flush counters.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic         clk_i,
    input  logic         rst_i,
    if_id_stage_if.slave bus
);
    import riscv_pkg::*;

    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] pc_p1;
    logic [XLEN-1:0] instr_p1;
    logic            vld_p1;
    logic            eff_flush;

    // A stalled branch is re-resolved once load data arrives, so stall masks flush.
    assign eff_flush = bus.Flush_i & ~bus.Stall_i;

    always_comb begin
        pc_nxt = pc_p0 + PC_INCR;
        if (!bus.PCWrite_i)
            pc_nxt = pc_p0;
        else if (eff_flush)
            pc_nxt = bus.BranchTarget_i;
    end

    // Stage p0: program counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            pc_p0 <= RESET_PC;
        else
            pc_p0 <= pc_nxt;
    end

    // Stage p1: IF/ID register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_p1    <= '0;
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
        end else if (bus.Stall_i) begin
            pc_p1    <= pc_p1;
            instr_p1 <= instr_p1;
            vld_p1   <= vld_p1;
        end else if (eff_flush) begin
            pc_p1    <= '0;
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
        end else begin
            pc_p1    <= pc_p0;
            instr_p1 <= bus.instr_i;
            vld_p1   <= 1'b1;
        end
    end

    assign bus.instr_addr_o  = pc_p0;
    assign bus.IF_ID_PC_o    = pc_p1;
    assign bus.IF_ID_Instr_o = instr_p1;
    assign bus.IF_ID_Valid_o = vld_p1;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (bus.Stall_i),
        .count_o (bus.StallCount_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (eff_flush),
        .count_o (bus.FlushCount_o)
    );

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: fetch, stall, flush, async reset and counter saturation.
module tb_if_id_stage;

    logic clk;
    logic rst_n;
    logic rst4_n;
    int   vectors;
    int   miscompares;

    if_id_stage_if #(.CNT_W(16)) bus ();
    if_id_stage_if #(.CNT_W(4))  bus4 ();

    if_id_stage #(.CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    if_id_stage #(.CNT_W(4)) dut4 (
        .clk_i (clk),
        .rst_i (rst4_n),
        .bus   (bus4)
    );

    // Instruction memory model: data is a scrambled copy of the address
    assign bus.instr_i  = bus.instr_addr_o ^ 32'hA5A5_0000;
    assign bus4.instr_i = bus4.instr_addr_o ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic vld);
        check({tag, "_pc"},    bus.IF_ID_PC_o,    pc);
        check({tag, "_instr"}, bus.IF_ID_Instr_o, instr);
        check({tag, "_vld"},   {31'd0, bus.IF_ID_Valid_o}, {31'd0, vld});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        rst4_n = 1'b0;
        bus.PCWrite_i      = 1'b1;
        bus.Stall_i        = 1'b0;
        bus.Flush_i        = 1'b0;
        bus.BranchTarget_i = 32'h0;
        bus4.PCWrite_i      = 1'b1;
        bus4.Stall_i        = 1'b0;
        bus4.Flush_i        = 1'b0;
        bus4.BranchTarget_i = 32'h0;

        repeat (2) step();
        check("rst_addr", bus.instr_addr_o, 32'h0);
        chk_ifid("rst", 32'h0, 32'h0000_0013, 1'b0);
        check("rst_scnt", {16'd0, bus.StallCount_o}, 32'd0);
        check("rst_fcnt", {16'd0, bus.FlushCount_o}, 32'd0);

        // Free run
        rst_n = 1'b1;
        check("run_addr0", bus.instr_addr_o, 32'h0);
        step();
        check("run_addr1", bus.instr_addr_o, 32'h4);
        chk_ifid("run1", 32'h0, 32'hA5A5_0000, 1'b1);
        step();
        check("run_addr2", bus.instr_addr_o, 32'h8);
        chk_ifid("run2", 32'h4, 32'hA5A5_0004, 1'b1);

        // Load-use stall at PC=8
        bus.PCWrite_i = 1'b0;
        bus.Stall_i   = 1'b1;
        step();
        check("lu_addr", bus.instr_addr_o, 32'h8);
        check("lu_pc", bus.IF_ID_PC_o, 32'h4);
        check("lu_scnt", {16'd0, bus.StallCount_o}, 32'd1);
        bus.PCWrite_i = 1'b1;
        bus.Stall_i   = 1'b0;
        step();
        check("lu_addr2", bus.instr_addr_o, 32'hC);
        chk_ifid("lu_after", 32'h8, 32'hA5A5_0008, 1'b1);

        // Branch flush at PC=12
        bus.Flush_i        = 1'b1;
        bus.BranchTarget_i = 32'h100;
        step();
        check("fl_addr", bus.instr_addr_o, 32'h100);
        chk_ifid("fl_bub", 32'h0, 32'h0000_0013, 1'b0);
        check("fl_fcnt", {16'd0, bus.FlushCount_o}, 32'd1);
        bus.Flush_i = 1'b0;
        step();
        check("fl_addr2", bus.instr_addr_o, 32'h104);
        chk_ifid("fl_tgt", 32'h100, 32'hA5A5_0100, 1'b1);

        // Stall masks flush
        bus.Stall_i        = 1'b1;
        bus.PCWrite_i      = 1'b0;
        bus.Flush_i        = 1'b1;
        bus.BranchTarget_i = 32'h200;
        step();
        check("sf_addr", bus.instr_addr_o, 32'h104);
        chk_ifid("sf_hold", 32'h100, 32'hA5A5_0100, 1'b1);
        check("sf_fcnt", {16'd0, bus.FlushCount_o}, 32'd1);
        check("sf_scnt", {16'd0, bus.StallCount_o}, 32'd2);
        bus.Stall_i   = 1'b0;
        bus.PCWrite_i = 1'b1;
        step();
        check("sf_addr2", bus.instr_addr_o, 32'h200);
        chk_ifid("sf_bub", 32'h0, 32'h0000_0013, 1'b0);
        check("sf_fcnt2", {16'd0, bus.FlushCount_o}, 32'd2);
        bus.Flush_i = 1'b0;
        step();
        check("sf_addr3", bus.instr_addr_o, 32'h204);
        check("sf_pc3", bus.IF_ID_PC_o, 32'h200);

        // Stall with PCWrite=1: the instruction at 0x204 is skipped
        bus.Stall_i = 1'b1;
        step();
        check("sk_addr", bus.instr_addr_o, 32'h208);
        check("sk_pc", bus.IF_ID_PC_o, 32'h200);
        check("sk_scnt", {16'd0, bus.StallCount_o}, 32'd3);
        bus.Stall_i = 1'b0;
        step();
        check("sk_addr2", bus.instr_addr_o, 32'h20C);
        chk_ifid("sk_after", 32'h208, 32'hA5A5_0208, 1'b1);

        // PCWrite=0 without stall re-fetches the same PC
        bus.PCWrite_i = 1'b0;
        step();
        check("rf_addr", bus.instr_addr_o, 32'h20C);
        chk_ifid("rf1", 32'h20C, 32'hA5A5_020C, 1'b1);
        bus.PCWrite_i = 1'b1;
        step();
        check("rf_addr2", bus.instr_addr_o, 32'h210);
        check("rf_pc2", bus.IF_ID_PC_o, 32'h20C);

        // PC wrap at top of address space
        bus.Flush_i        = 1'b1;
        bus.BranchTarget_i = 32'hFFFF_FFFC;
        step();
        check("wr_addr", bus.instr_addr_o, 32'hFFFF_FFFC);
        check("wr_fcnt", {16'd0, bus.FlushCount_o}, 32'd3);
        bus.Flush_i = 1'b0;
        step();
        check("wr_addr2", bus.instr_addr_o, 32'h0);
        chk_ifid("wr", 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1'b1);
        repeat (2) step();
        check("wr_addr3", bus.instr_addr_o, 32'h8);
        check("wr_pc3", bus.IF_ID_PC_o, 32'h4);

        // Asynchronous reset while stalled
        bus.Stall_i   = 1'b1;
        bus.PCWrite_i = 1'b0;
        step();
        check("ar_scnt_pre", {16'd0, bus.StallCount_o}, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_addr", bus.instr_addr_o, 32'h0);
        chk_ifid("ar", 32'h0, 32'h0000_0013, 1'b0);
        check("ar_scnt", {16'd0, bus.StallCount_o}, 32'd0);
        check("ar_fcnt", {16'd0, bus.FlushCount_o}, 32'd0);
        step();
        bus.Stall_i   = 1'b0;
        bus.PCWrite_i = 1'b1;
        rst_n = 1'b1;
        check("ar_addr_rel", bus.instr_addr_o, 32'h0);
        step();
        check("ar_addr1", bus.instr_addr_o, 32'h4);
        chk_ifid("ar_run", 32'h0, 32'hA5A5_0000, 1'b1);

        // Saturation on the narrow instance
        rst4_n = 1'b1;
        bus4.Stall_i = 1'b1;
        repeat (8) step();
        check("sat_8", {28'd0, bus4.StallCount_o}, 32'd8);
        repeat (7) step();
        check("sat_15", {28'd0, bus4.StallCount_o}, 32'd15);
        repeat (5) step();
        check("sat_20", {28'd0, bus4.StallCount_o}, 32'd15);
        check("sat_fcnt", {28'd0, bus4.FlushCount_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
